// File: rtl/sub_atom_pkg.sv
// Shared types, selector-word layout, config addresses and atom helper functions
// for the subtract-atom scheduler.
package sub_atom_pkg;

  typedef logic [31:0] int32_t;
  typedef logic [1:0]  int2_t;
  typedef logic        bool;

  typedef enum logic {RUN, STALL} fsm_t;

  localparam int SEL_W     = 15;
  localparam int SEL1_OFF  = 0;
  localparam int SEL2_OFF  = 1;
  localparam int SEL3_OFF  = 3;
  localparam int SEL4_OFF  = 4;
  localparam int SEL5_OFF  = 6;
  localparam int SEL6_OFF  = 7;
  localparam int SEL7_OFF  = 9;
  localparam int SEL8_OFF  = 11;
  localparam int RELOP_OFF = 13;

  localparam logic [2:0] CFG_CONS1 = 3'd0;
  localparam logic [2:0] CFG_CONS2 = 3'd1;
  localparam logic [2:0] CFG_CONS3 = 3'd2;
  localparam logic [2:0] CFG_CONS4 = 3'd3;
  localparam logic [2:0] CFG_CONS5 = 3'd4;
  localparam logic [2:0] CFG_SEL   = 3'd5;
  localparam logic [2:0] CFG_STATE = 3'd6;
  localparam logic [2:0] CFG_CLR   = 3'd7;

  function automatic int32_t mux2(input int32_t a, input int32_t b, input bool s);
    return s ? b : a;
  endfunction

  // Select value 3 aliases to the third input.
  function automatic int32_t mux3(input int32_t a, input int32_t b, input int32_t c,
                                  input int2_t s);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  function automatic bool rel_op(input int32_t x, input int32_t y, input int2_t op);
    case (op)
      2'd0:    return x != y;
      2'd1:    return x < y;
      2'd2:    return x > y;
      default: return x == y;
    endcase
  endfunction

endpackage

// File: rtl/sub_atom_dp.sv
// Combinational subtract-atom: relational guard picks one of two
// state +/- operand expressions.
module sub_atom_dp
  import sub_atom_pkg::*;
(
  input  int32_t           state_i,
  input  int32_t           pkt1_i,
  input  int32_t           pkt2_i,
  input  int32_t           cons1_i,
  input  int32_t           cons2_i,
  input  int32_t           cons3_i,
  input  int32_t           cons4_i,
  input  int32_t           cons5_i,
  input  logic [SEL_W-1:0] sel_i,
  output int32_t           new_o
);

  bool    guard;
  int32_t lhs, rhs;

  always_comb begin
    lhs   = mux2(state_i, '0, sel_i[SEL1_OFF]);
    rhs   = mux3(pkt1_i, pkt2_i, cons1_i, sel_i[SEL2_OFF +: 2]);
    guard = rel_op(lhs, rhs, sel_i[RELOP_OFF +: 2]);
    if (guard)
      new_o = mux2(state_i, '0, sel_i[SEL3_OFF])
            + mux3(pkt1_i, pkt2_i, cons2_i, sel_i[SEL4_OFF +: 2])
            - mux3(pkt1_i, pkt2_i, cons4_i, sel_i[SEL7_OFF +: 2]);
    else
      new_o = mux2(state_i, '0, sel_i[SEL5_OFF])
            + mux3(pkt1_i, pkt2_i, cons3_i, sel_i[SEL6_OFF +: 2])
            - mux3(pkt1_i, pkt2_i, cons5_i, sel_i[SEL8_OFF +: 2]);
  end

endmodule

// File: rtl/sub_atom_sched.sv
// Round-robin scheduler sharing one stateful subtract-atom between NUM_REQ lanes;
// owns the atom config registers, the state register and a 1-deep result slot.
module sub_atom_sched
  import sub_atom_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_pkt_1,
  input  logic [NUM_REQ*32-1:0] req_pkt_2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_read,
  output logic [31:0]           rsp_write,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [31:0]           cfg_data,
  output logic [31:0]           state_q,
  output logic [CNT_W-1:0]      op_cnt
);

  fsm_t             fsm_q, fsm_d;
  logic [ID_W-1:0]  ptr_q, gnt_id;
  logic             gnt_vld, slot_free, accept;
  int32_t           cons_q [5];
  logic [SEL_W-1:0] sel_q;
  int32_t           pkt1, pkt2, new_val;
  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  int32_t           rsp_read_q, rsp_write_q;
  logic [CNT_W-1:0] op_cnt_q;

  // First valid lane at or after the pointer, with wrap.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign slot_free = !rsp_valid_q || rsp_ready;
  assign accept    = gnt_vld && (fsm_q == RUN) && slot_free && !cfg_we;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  assign pkt1 = req_pkt_1[int'(gnt_id)*32 +: 32];
  assign pkt2 = req_pkt_2[int'(gnt_id)*32 +: 32];

  sub_atom_dp u_dp (
    .state_i (state_q),
    .pkt1_i  (pkt1),
    .pkt2_i  (pkt2),
    .cons1_i (cons_q[0]),
    .cons2_i (cons_q[1]),
    .cons3_i (cons_q[2]),
    .cons4_i (cons_q[3]),
    .cons5_i (cons_q[4]),
    .sel_i   (sel_q),
    .new_o   (new_val)
  );

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      RUN:     if (rsp_valid_q && !rsp_ready) fsm_d = STALL;
      STALL:   if (rsp_ready) fsm_d = RUN;
      default: fsm_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= RUN;
    else     fsm_q <= fsm_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= '0;
      cons_q      <= '{default: '0};
      sel_q       <= '0;
      op_cnt_q    <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_read_q  <= '0;
      rsp_write_q <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          CFG_SEL:   sel_q    <= cfg_data[SEL_W-1:0];
          CFG_STATE: state_q  <= cfg_data;
          CFG_CLR:   op_cnt_q <= '0;
          default:   cons_q[cfg_addr] <= cfg_data;
        endcase
      end
      if (accept) begin
        state_q     <= new_val;
        ptr_q       <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= gnt_id;
        rsp_read_q  <= state_q;
        rsp_write_q <= new_val;
        if (op_cnt_q != {CNT_W{1'b1}}) op_cnt_q <= op_cnt_q + 1'b1;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_read  = rsp_read_q;
  assign rsp_write = rsp_write_q;
  assign op_cnt    = op_cnt_q;

endmodule
